txpll_lane_reset_seq: RTL and testbench
=======================================

Name: txpll_lane_reset_seq

Overview:
- Reset/initialisation sequencer directly downstream of the fabric-referenced transceiver TX PLL in the digitizer JESD-side link.
- Consumes the PLL's PLL_LOCK flag and the TX lane's ready status.
- Sequences the lane PMA and PCS resets: release only after a debounced, stable lock.
- Supervises lock loss and timeouts, with bounded retry and a sticky FAULT state.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before releasing PMA reset
PMA_HOLD_CYCLES, 64, cycles both resets are held in HOLD state
PCS_DELAY_CYCLES, 32, cycles between PMA reset release and PCS reset release
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before timeout
READY_TIMEOUT_CYCLES, 65536, max cycles in WAIT_READY before timeout
MAX_RETRIES, 3, timeouts tolerated before FAULT
CNT_W, 17, width of the shared state counter; must hold max of all cycle parameters

Ports:
CLK  in  1  fabric clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
PLL_LOCK  in  1  TX PLL lock, asynchronous to CLK
LANE_READY  in  1  TX lane PCS ready, asynchronous to CLK
CLEAR_FAULT  in  1  synchronous pulse; exits FAULT
PMA_RESET  out  1  active-high lane PMA reset
PCS_RESET  out  1  active-high lane PCS reset
TX_READY  out  1  link may transmit
FAULT  out  1  retry budget exhausted, sticky
RETRY_COUNT  out  2  timeouts since last READY or fault clear
STATE  out  3  HOLD=0, WAIT_LOCK=1, LOCK_STABLE=2, PMA_REL=3, WAIT_READY=4, READY=5, FAULT=6

Behaviour:
- Input synchronisation:
  - PLL_LOCK and LANE_READY each pass through a 2-FF synchroniser; the FSM uses only the synced values (lock_s, ready_s).
  - Input-to-FSM latency is 2 cycles.
  - RST clears both synchroniser stages to 0.
- Reset: while RST=1, the outputs are:
  - STATE=HOLD, counter=0, RETRY_COUNT=0
  - PMA_RESET=1, PCS_RESET=1
  - TX_READY=0, FAULT=0
- Outputs are decoded from the state register only; there is no input-to-output combinational path.
  - PMA_RESET=1 in HOLD, WAIT_LOCK, LOCK_STABLE, FAULT.
  - PCS_RESET=1 in every state except WAIT_READY and READY.
  - TX_READY=1 only in READY.
  - FAULT=1 only in FAULT.
- Counter: a single counter, cleared to 0 on every state entry and incremented each cycle in the state.
  - "N cycles" below means the state is left when counter==N-1.
- Transitions (priority order within each state as listed):
  - HOLD: after PMA_HOLD_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK: lock_s=1 -> LOCK_STABLE; else after LOCK_TIMEOUT_CYCLES cycles -> timeout.
  - LOCK_STABLE: lock_s=0 -> WAIT_LOCK (the timeout window restarts); else after LOCK_STABLE_CYCLES cycles -> PMA_REL.
  - PMA_REL: lock_s=0 -> HOLD; else after PCS_DELAY_CYCLES cycles -> WAIT_READY.
  - WAIT_READY: lock_s=0 -> HOLD; ready_s=1 -> READY; else after READY_TIMEOUT_CYCLES cycles -> timeout.
  - READY:
    - lock_s=0 or ready_s=0 -> HOLD (no retry increment).
    - Entering READY clears RETRY_COUNT to 0.
  - Timeout: if RETRY_COUNT==MAX_RETRIES -> FAULT; else RETRY_COUNT+1 and -> HOLD.
  - FAULT:
    - Ignores PLL_LOCK and LANE_READY.
    - CLEAR_FAULT=1 -> RETRY_COUNT=0, -> HOLD.
- Simultaneous events:
  - Lock loss beats timeout in the same cycle: -> HOLD, no increment.
  - ready_s and timeout in the same cycle in WAIT_READY: READY wins.
  - CLEAR_FAULT outside FAULT is ignored.
- RST mid-sequence: all state returns to reset values on the next edge, regardless of the current state.
- RETRY_COUNT saturates by construction (max MAX_RETRIES); MAX_RETRIES must be ≤3.

Test Plan (params: LOCK_STABLE=8, PMA_HOLD=4, PCS_DELAY=4, both timeouts=32, MAX_RETRIES=2):
- Nominal bring-up: PLL_LOCK=1 and LANE_READY=1 held from reset release.
  -> PMA_RESET falls 4+2+8=14 cycles after RST drops (±sync alignment, checked exactly against the model).
  -> PCS_RESET falls 4 cycles later.
  -> TX_READY=1 one cycle after entering WAIT_READY plus 2-cycle ready sync.
  -> RETRY_COUNT=0.
- Lock glitch in LOCK_STABLE: PLL_LOCK drops for 1 cycle at stable count 5.
  -> STATE returns to WAIT_LOCK; PMA_RESET stays 1.
  -> A full 8-cycle stable window is required afterwards.
- Lock never asserts: PLL_LOCK=0.
  -> RETRY_COUNT steps 1, 2.
  -> FAULT=1 and STATE=6 exactly 3×(4+32)=108 cycles after the first cycle with RST=0.
  -> FAULT holds indefinitely.
- Fault clear: pulse CLEAR_FAULT in FAULT with PLL_LOCK=1 and LANE_READY=1.
  -> FAULT=0, RETRY_COUNT=0, STATE=HOLD next cycle.
  -> Reaches READY.
- Loss in READY: drop LANE_READY while in READY.
  -> 2 cycles later STATE=HOLD, TX_READY=0, PMA_RESET=1, PCS_RESET=1, RETRY_COUNT unchanged.
- Reset mid-sequence and same-cycle priority:
  - Assert RST in PMA_REL -> all outputs at reset values next edge.
  - Separately, force lock_s=0 on the same cycle WAIT_READY times out -> HOLD, RETRY_COUNT not incremented.

Source files
------------

// File: rtl/txpll_lane_reset_seq.sv
// Lane PMA/PCS reset sequencer behind the TX PLL: debounces lock, releases resets in order,
// supervises lock loss and timeouts with bounded retry and a sticky fault.
module txpll_lane_reset_seq #(
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int PMA_HOLD_CYCLES      = 64,
    parameter int PCS_DELAY_CYCLES     = 32,
    parameter int LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int READY_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES          = 3,
    parameter int CNT_W                = 17
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCK,
    input  logic       LANE_READY,
    input  logic       CLEAR_FAULT,
    output logic       PMA_RESET,
    output logic       PCS_RESET,
    output logic       TX_READY,
    output logic       FAULT,
    output logic [1:0] RETRY_COUNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_HOLD        = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_PMA_REL     = 3'd3,
        ST_WAIT_READY  = 3'd4,
        ST_READY       = 3'd5,
        ST_FAULT       = 3'd6
    } state_t;

    // Terminal counter values: a state lasting N cycles is left when the counter reads N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(PMA_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PCS_LAST      = CNT_W'(PCS_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] READY_TO_LAST = CNT_W'(READY_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX     = 2'(MAX_RETRIES);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       retry;
    logic [1:0]       retry_next;
    logic             timeout;
    logic             lock_meta;
    logic             lock_s;
    logic             ready_meta;
    logic             ready_s;

    // PLL_LOCK and LANE_READY come from other clock domains.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            ready_meta <= 1'b0;
            ready_s    <= 1'b0;
        end else begin
            lock_meta  <= PLL_LOCK;
            lock_s     <= lock_meta;
            ready_meta <= LANE_READY;
            ready_s    <= ready_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_HOLD;
            cnt   <= '0;
            retry <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            retry <= retry_next;
        end
    end

    // Lock loss is tested before any timeout so a lost lock never consumes a retry.
    always_comb begin
        state_next = state;
        retry_next = retry;
        timeout    = 1'b0;

        case (state)
            ST_HOLD: begin
                if (cnt == HOLD_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)                    state_next = ST_LOCK_STABLE;
                else if (cnt == LOCK_TO_LAST)  timeout    = 1'b1;
            end
            ST_LOCK_STABLE: begin
                if (!lock_s)                   state_next = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST)   state_next = ST_PMA_REL;
            end
            ST_PMA_REL: begin
                if (!lock_s)                   state_next = ST_HOLD;
                else if (cnt == PCS_LAST)      state_next = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (!lock_s) begin
                    state_next = ST_HOLD;
                end else if (ready_s) begin
                    state_next = ST_READY;
                    retry_next = 2'd0;
                end else if (cnt == READY_TO_LAST) begin
                    timeout = 1'b1;
                end
            end
            ST_READY: begin
                if (!lock_s || !ready_s)       state_next = ST_HOLD;
            end
            ST_FAULT: begin
                if (CLEAR_FAULT) begin
                    state_next = ST_HOLD;
                    retry_next = 2'd0;
                end
            end
            default: state_next = ST_HOLD;
        endcase

        if (timeout) begin
            if (retry == RETRY_MAX) begin
                state_next = ST_FAULT;
            end else begin
                state_next = ST_HOLD;
                retry_next = retry + 2'd1;
            end
        end

        cnt_next = (state_next != state) ? '0 : cnt + 1'b1;
    end

    always_comb begin
        PMA_RESET   = (state == ST_HOLD) || (state == ST_WAIT_LOCK) ||
                      (state == ST_LOCK_STABLE) || (state == ST_FAULT);
        PCS_RESET   = !((state == ST_WAIT_READY) || (state == ST_READY));
        TX_READY    = (state == ST_READY);
        FAULT       = (state == ST_FAULT);
        RETRY_COUNT = retry;
        STATE       = state;
    end

endmodule

// File: tb/tb_txpll_lane_reset_seq.sv
// Directed bench for txpll_lane_reset_seq using shortened parameters; expected states and
// retry counts are hand-derived edge by edge from reset release.
module tb_txpll_lane_reset_seq;

    localparam logic [2:0] S_HOLD   = 3'd0;
    localparam logic [2:0] S_WLOCK  = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_PMAREL = 3'd3;
    localparam logic [2:0] S_WREADY = 3'd4;
    localparam logic [2:0] S_READY  = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PLL_LOCK = 1'b0;
    logic       LANE_READY = 1'b0;
    logic       CLEAR_FAULT = 1'b0;
    logic       PMA_RESET;
    logic       PCS_RESET;
    logic       TX_READY;
    logic       FAULT;
    logic [1:0] RETRY_COUNT;
    logic [2:0] STATE;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst;
        logic       lock;
        logic       ready;
        logic       clr;
        int         cycles;
        logic [2:0] st;
        logic [1:0] retry;
    } vec_t;

    vec_t vecs[$];

    txpll_lane_reset_seq #(
        .LOCK_STABLE_CYCLES  (8),
        .PMA_HOLD_CYCLES     (4),
        .PCS_DELAY_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .READY_TIMEOUT_CYCLES(32),
        .MAX_RETRIES         (2),
        .CNT_W               (17)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PLL_LOCK   (PLL_LOCK),
        .LANE_READY (LANE_READY),
        .CLEAR_FAULT(CLEAR_FAULT),
        .PMA_RESET  (PMA_RESET),
        .PCS_RESET  (PCS_RESET),
        .TX_READY   (TX_READY),
        .FAULT      (FAULT),
        .RETRY_COUNT(RETRY_COUNT),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string name, input int tag, input logic [2:0] act,
                             input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, tag, act, exp);
        end
    endtask

    // Output decode expected for a given state.
    task automatic check_output(input int tag, input logic [2:0] st, input logic [1:0] rt);
        check_val("STATE",       tag, STATE, st);
        check_val("RETRY_COUNT", tag, {1'b0, RETRY_COUNT}, {1'b0, rt});
        check_val("PMA_RESET",   tag, {2'b0, PMA_RESET},
                  {2'b0, (st == S_HOLD) || (st == S_WLOCK) || (st == S_STABLE) || (st == S_FAULT)});
        check_val("PCS_RESET",   tag, {2'b0, PCS_RESET}, {2'b0, !((st == S_WREADY) || (st == S_READY))});
        check_val("TX_READY",    tag, {2'b0, TX_READY}, {2'b0, st == S_READY});
        check_val("FAULT",       tag, {2'b0, FAULT}, {2'b0, st == S_FAULT});
    endtask

    // Drive inputs just after a sample point, then advance n edges and settle.
    task automatic apply_stimulus(input logic rst, input logic lock, input logic ready,
                                  input logic clr, input int n);
        RST         = rst;
        PLL_LOCK    = lock;
        LANE_READY  = ready;
        CLEAR_FAULT = clr;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic void add_vec(input logic rst, input logic lock, input logic ready,
                                    input logic clr, input int n, input logic [2:0] st,
                                    input logic [1:0] rt);
        vec_t v;
        v.rst = rst; v.lock = lock; v.ready = ready; v.clr = clr;
        v.cycles = n; v.st = st; v.retry = rt;
        vecs.push_back(v);
    endfunction

    initial begin
        // Nominal bring-up: PMA_REL entered on edge 13, WAIT_READY on 17, READY on 18.
        add_vec(1, 1, 1, 0,  2, S_HOLD,   0);
        add_vec(0, 1, 1, 0, 12, S_STABLE, 0);
        add_vec(0, 1, 1, 0,  1, S_PMAREL, 0);
        add_vec(0, 1, 1, 0,  3, S_PMAREL, 0);
        add_vec(0, 1, 1, 0,  1, S_WREADY, 0);
        add_vec(0, 1, 1, 0,  1, S_READY,  0);
        add_vec(0, 1, 1, 1,  1, S_READY,  0);
        add_vec(0, 1, 1, 0,  4, S_READY,  0);
        // Lane ready lost: two sync edges, then HOLD on the third.
        add_vec(0, 1, 0, 0,  2, S_READY,  0);
        add_vec(0, 1, 0, 0,  1, S_HOLD,   0);
        // One-cycle lock glitch seen by the FSM at stable count 5.
        add_vec(1, 1, 0, 0,  2, S_HOLD,   0);
        add_vec(0, 1, 0, 0,  8, S_STABLE, 0);
        add_vec(0, 0, 0, 0,  1, S_STABLE, 0);
        add_vec(0, 1, 0, 0,  2, S_WLOCK,  0);
        add_vec(0, 1, 0, 0,  8, S_STABLE, 0);
        add_vec(0, 1, 0, 0,  1, S_PMAREL, 0);
        // Lock never asserts: timeouts on edges 36 and 72, FAULT on edge 108.
        add_vec(1, 0, 0, 0,  2, S_HOLD,   0);
        add_vec(0, 0, 0, 0, 35, S_WLOCK,  0);
        add_vec(0, 0, 0, 0,  1, S_HOLD,   1);
        add_vec(0, 0, 0, 0, 35, S_WLOCK,  1);
        add_vec(0, 0, 0, 0,  1, S_HOLD,   2);
        add_vec(0, 0, 0, 0, 35, S_WLOCK,  2);
        add_vec(0, 0, 0, 0,  1, S_FAULT,  2);
        add_vec(0, 1, 1, 0, 40, S_FAULT,  2);
        // Fault clear, then full bring-up with lock/ready already synced.
        add_vec(0, 1, 1, 1,  1, S_HOLD,   0);
        add_vec(0, 1, 1, 0, 17, S_WREADY, 0);
        add_vec(0, 1, 1, 0,  1, S_READY,  0);
        // WAIT_READY timeout increments retry; next READY entry clears it.
        add_vec(1, 1, 0, 0,  2, S_HOLD,   0);
        add_vec(0, 1, 0, 0, 48, S_WREADY, 0);
        add_vec(0, 1, 0, 0,  1, S_HOLD,   1);
        add_vec(0, 1, 1, 0, 17, S_WREADY, 1);
        add_vec(0, 1, 1, 0,  1, S_READY,  0);
        // Ready arriving on the timeout cycle wins.
        add_vec(1, 1, 0, 0,  2, S_HOLD,   0);
        add_vec(0, 1, 0, 0, 46, S_WREADY, 0);
        add_vec(0, 1, 1, 0,  2, S_WREADY, 0);
        add_vec(0, 1, 1, 0,  1, S_READY,  0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].lock, vecs[i].ready, vecs[i].clr, vecs[i].cycles);
            check_output(i, vecs[i].st, vecs[i].retry);
        end

        // RST asserted while in PMA_REL returns everything to reset values on the next edge.
        apply_stimulus(1, 1, 1, 0, 2);
        apply_stimulus(0, 1, 1, 0, 14);
        check_output(100, S_PMAREL, 0);
        apply_stimulus(1, 1, 1, 0, 1);
        check_output(101, S_HOLD, 0);

        // Lock loss reaches the FSM on the same edge WAIT_READY would time out.
        apply_stimulus(0, 1, 0, 0, 2);
        check_output(102, S_HOLD, 0);
        apply_stimulus(1, 1, 0, 0, 1);
        apply_stimulus(0, 1, 0, 0, 46);
        check_output(103, S_WREADY, 0);
        apply_stimulus(0, 0, 0, 0, 2);
        check_output(104, S_WREADY, 0);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output(105, S_HOLD, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
